// File: rtl/drive_pkg.sv
// Shared types and helpers for the floppy drive head/save controller.
package drive_pkg;

  // Width of half-track and track fields.
  localparam int HT_W = 7;

  // One pending save: which side and which whole track to write back.
  typedef struct packed {
    logic            side;
    logic [HT_W-1:0] trk;
  } save_entry_t;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_FWD,
    STEP_BACK
  } step_dir_e;

  // Stepper phases advance one position per quarter turn; a change of one
  // phase is a step, a change of two is ambiguous and is ignored.
  function automatic step_dir_e step_dir(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] nxt;
    logic [1:0] prv;
    nxt = prev + 2'd1;
    prv = prev - 2'd1;
    if (cur == nxt)      return STEP_FWD;
    else if (cur == prv) return STEP_BACK;
    else                 return STEP_NONE;
  endfunction

endpackage

// File: rtl/drive_save_fifo.sv
// Small FIFO of pending track saves; push+pop in one cycle is allowed even when full.
module drive_save_fifo
  import drive_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic        flush_i,
  input  save_entry_t din_i,
  output save_entry_t head_o,
  output logic        full_o,
  output logic        empty_o,
  output logic        dropped_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  save_entry_t   mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == CW'(DEPTH));
  assign do_pop    = pop_i & ~empty_o & ~flush_i;
  assign do_push   = push_i & (~full_o | do_pop) & ~flush_i;
  assign dropped_o = push_i & full_o & ~do_pop & ~flush_i;
  // Empty queue presents an all-zero head so the outputs are defined.
  assign head_o    = empty_o ? '0 : mem_q[rd_q];

  // Pointer and occupancy next-state.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = ptr_inc(wr_q);
      if (do_pop)  rd_d = ptr_inc(rd_q);
      if (do_push && !do_pop) cnt_d = cnt_q + CW'(1);
      else if (do_pop && !do_push) cnt_d = cnt_q - CW'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; occupancy gates what is visible at the head.
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/drive_head_ctrl.sv
// Head position, write-protect sense and dirty-track save requests for the emulated drive.
module drive_head_ctrl
  import drive_pkg::*;
#(
  parameter int HT_MAX    = 80,
  parameter int HT_RESET  = 36,
  parameter int SIDES     = 1,
  parameter int CHG_TICKS = 15000000,
  parameter int QDEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      stp,
  input  logic            mtr,
  input  logic            side,
  input  logic            buff_we,
  input  logic            disk_change,
  input  logic            disk_readonly,
  output logic [HT_W-1:0] track,
  output logic [HT_W-1:0] half_track,
  output logic            side_o,
  output logic            tr00_sense_n,
  output logic            wps_n,
  output logic            save_req,
  output logic [HT_W-1:0] save_trk,
  output logic            save_side,
  input  logic            save_ack,
  output logic            save_ovf
);

  localparam int CNT_W = $clog2(CHG_TICKS + 1);

  logic [HT_W-1:0]  ht_q, ht_d;
  logic [1:0]       stp_q;
  logic             side_q, side_d, mtr_q, dc_q;
  logic             dirty_q, dirty_d, ro_q, ro_d, ovf_q, ovf_d;
  logic [CNT_W-1:0] chg_q, chg_d;
  logic             dc_rise, trigger, push;
  step_dir_e        dir;
  save_entry_t      entry, head;
  logic             fifo_full, fifo_empty, fifo_drop;

  // Decode steps, save triggers, dirty tracking and the disk-change countdown.
  always_comb begin
    side_d  = (SIDES == 2) ? side : 1'b0;
    dir     = mtr ? step_dir(stp_q, stp) : STEP_NONE;
    dc_rise = disk_change & ~dc_q;
    trigger = (dir != STEP_NONE) | (side_d != side_q) | (mtr_q & ~mtr);
    // A new image makes any pending save stale, so nothing is queued that cycle.
    push    = trigger & (dirty_q | buff_we) & ~dc_rise;
    entry   = '{side: side_q, trk: {1'b0, ht_q[HT_W-1:1]}};

    ht_d = ht_q;
    unique case (dir)
      STEP_FWD:  if (ht_q < HT_W'(HT_MAX)) ht_d = ht_q + HT_W'(1);
      STEP_BACK: if (ht_q > HT_W'(1))      ht_d = ht_q - HT_W'(1);
      default:   ht_d = ht_q;
    endcase

    // A write coinciding with a save belongs to the track being saved.
    dirty_d = dirty_q;
    if (dc_rise)      dirty_d = 1'b0;
    else if (push)    dirty_d = 1'b0;
    else if (buff_we) dirty_d = 1'b1;

    ro_d  = dc_rise ? disk_readonly : ro_q;
    chg_d = dc_rise ? CNT_W'(CHG_TICKS) : ((chg_q != '0) ? chg_q - CNT_W'(1) : chg_q);
    ovf_d = ovf_q | fifo_drop;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ht_q    <= HT_W'(HT_RESET);
      stp_q   <= '0;
      side_q  <= 1'b0;
      mtr_q   <= 1'b0;
      dc_q    <= 1'b0;
      dirty_q <= 1'b0;
      ro_q    <= 1'b0;
      chg_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      ht_q    <= ht_d;
      stp_q   <= stp;
      side_q  <= side_d;
      mtr_q   <= mtr;
      dc_q    <= disk_change;
      dirty_q <= dirty_d;
      ro_q    <= ro_d;
      chg_q   <= chg_d;
      ovf_q   <= ovf_d;
    end
  end

  drive_save_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (push),
    .pop_i     (save_ack),
    .flush_i   (dc_rise),
    .din_i     (entry),
    .head_o    (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .dropped_o (fifo_drop)
  );

  assign half_track   = ht_q;
  assign track        = {1'b0, ht_q[HT_W-1:1]};
  assign side_o       = side_q;
  assign tr00_sense_n = |ht_q[HT_W-1:1];
  assign wps_n        = ~ro_q ^ (chg_q != '0);
  assign save_req     = ~fifo_empty;
  assign save_trk     = head.trk;
  assign save_side    = head.side;
  assign save_ovf     = ovf_q;

endmodule

// File: tb/tb_drive_head_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_drive_head_ctrl;

  localparam int HT_MAX    = 84;
  localparam int HT_RESET  = 36;
  localparam int SIDES     = 2;
  localparam int CHG_TICKS = 100;
  localparam int QDEPTH    = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] stp = '0;
  logic       mtr = 1'b0, side = 1'b0, buff_we = 1'b0;
  logic       disk_change = 1'b0, disk_readonly = 1'b0, save_ack = 1'b0;
  logic [6:0] track, half_track, save_trk;
  logic       side_o, tr00_sense_n, wps_n, save_req, save_side, save_ovf;

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural model state.
  int m_ht, m_side, m_dirty, m_mtr, m_stp, m_dc, m_ro, m_cnt, m_ovf;
  int m_q[$];

  always #5 clk = ~clk;

  drive_head_ctrl #(
    .HT_MAX(HT_MAX), .HT_RESET(HT_RESET), .SIDES(SIDES),
    .CHG_TICKS(CHG_TICKS), .QDEPTH(QDEPTH)
  ) dut (
    .clk(clk), .reset(reset), .stp(stp), .mtr(mtr), .side(side),
    .buff_we(buff_we), .disk_change(disk_change), .disk_readonly(disk_readonly),
    .track(track), .half_track(half_track), .side_o(side_o),
    .tr00_sense_n(tr00_sense_n), .wps_n(wps_n), .save_req(save_req),
    .save_trk(save_trk), .save_side(save_side), .save_ack(save_ack),
    .save_ovf(save_ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ht = HT_RESET; m_side = 0; m_dirty = 0; m_mtr = 0; m_stp = 0;
    m_dc = 0; m_ro = 0; m_cnt = 0; m_ovf = 0;
    m_q.delete();
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    int  old_trk, old_side, eff, d;
    bit  trig, push, rise;
    old_trk  = m_ht / 2;
    old_side = m_side;
    eff      = (SIDES == 2) ? int'(side) : 0;
    rise     = disk_change && (m_dc == 0);
    trig     = 0;
    if (mtr) begin
      d = (int'(stp) - m_stp + 4) % 4;
      if (d == 1) begin
        trig = 1;
        if (m_ht < HT_MAX) m_ht++;
      end else if (d == 3) begin
        trig = 1;
        if (m_ht > 1) m_ht--;
      end
    end
    if (eff != m_side) trig = 1;
    if (m_mtr == 1 && !mtr) trig = 1;
    push = trig && (m_dirty == 1 || buff_we) && !rise;
    if (rise) begin
      m_q.delete();
      m_dirty = 0;
      m_ro    = int'(disk_readonly);
      m_cnt   = CHG_TICKS;
    end else begin
      if (m_cnt > 0) m_cnt--;
      if (save_ack && m_q.size() > 0) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < QDEPTH) m_q.push_back(old_side * 128 + old_trk);
        else m_ovf = 1;
        m_dirty = 0;
      end else if (buff_we) begin
        m_dirty = 1;
      end
    end
    m_side = eff;
    m_mtr  = int'(mtr);
    m_stp  = int'(stp);
    m_dc   = int'(disk_change);
  endtask

  task automatic check_all();
    int busy;
    busy = (m_cnt != 0) ? 1 : 0;
    check("half_track", half_track, m_ht);
    check("track", track, m_ht / 2);
    check("side_o", side_o, m_side);
    check("tr00_sense_n", tr00_sense_n, (m_ht / 2 == 0) ? 0 : 1);
    check("wps_n", wps_n, (m_ro == 1) ? busy : 1 - busy);
    check("save_req", save_req, (m_q.size() > 0) ? 1 : 0);
    check("save_ovf", save_ovf, m_ovf);
    if (m_q.size() > 0) begin
      check("save_trk", save_trk, m_q[0] % 128);
      check("save_side", save_side, m_q[0] / 128);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    stp = '0; mtr = 0; side = 0; buff_we = 0;
    disk_change = 0; disk_readonly = 0; save_ack = 0;
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
    check_all();
  endtask

  task automatic step_fwd();
    stp = stp + 2'd1;
    tick();
  endtask

  task automatic step_back();
    stp = stp - 2'd1;
    tick();
  endtask

  task automatic ack();
    save_ack = 1;
    tick();
    save_ack = 0;
  endtask

  task automatic dirty_write();
    buff_we = 1;
    tick();
    buff_we = 0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values and a full forward phase cycle.
    do_reset();
    check("rst_track", track, 18);
    check("rst_wps_n", wps_n, 1);
    check("rst_save_req", save_req, 0);
    mtr = 1;
    tick();
    repeat (4) step_fwd();
    check("fwd4_half_track", half_track, 40);
    check("fwd4_track", track, 20);

    // Saturation at both ends, then no movement with motor off.
    do_reset();
    mtr = 1;
    tick();
    repeat (50) step_back();
    check("sat_low_half_track", half_track, 1);
    check("sat_low_tr00", tr00_sense_n, 0);
    repeat (100) step_fwd();
    check("sat_high_half_track", half_track, HT_MAX);
    mtr = 0;
    tick();
    repeat (4) step_back();
    check("mtr_off_half_track", half_track, HT_MAX);

    // Dirty track saved on step, then acknowledged.
    do_reset();
    mtr = 1;
    tick();
    dirty_write();
    step_fwd();
    check("save_req_set", save_req, 1);
    check("save_trk_18", save_trk, 18);
    check("save_side_0", save_side, 0);
    ack();
    check("save_req_clr", save_req, 0);

    // Overflow: three dirty steps, no ack.
    do_reset();
    mtr = 1;
    tick();
    repeat (3) begin
      dirty_write();
      step_fwd();
    end
    check("ovf_set", save_ovf, 1);
    check("ovf_head_trk", save_trk, 18);
    ack();
    check("ovf_second_trk", save_trk, 18);
    ack();
    check("ovf_drained", save_req, 0);
    check("ovf_sticky", save_ovf, 1);

    // Side change and motor-off triggers, then coincident triggers.
    do_reset();
    mtr = 1;
    tick();
    dirty_write();
    side = 1;
    tick();
    check("side_entry_side", save_side, 0);
    check("side_entry_trk", save_trk, 18);
    ack();
    dirty_write();
    mtr = 0;
    tick();
    check("mtr_entry_side", save_side, 1);
    check("mtr_entry_trk", save_trk, 18);
    ack();
    mtr = 1;
    tick();
    dirty_write();
    stp = stp + 2'd1; side = 0; mtr = 0;
    tick();
    check("coinc_req", save_req, 1);
    ack();
    check("coinc_single", save_req, 0);

    // Disk change: flush, dirty clear, write-protect toggle.
    do_reset();
    mtr = 1;
    tick();
    buff_we = 1;
    step_fwd();
    dirty_write();
    disk_readonly = 1;
    disk_change = 1;
    tick();
    disk_change = 0;
    check("dc_flush", save_req, 0);
    check("dc_wps_first", wps_n, 1);
    repeat (CHG_TICKS - 1) tick();
    check("dc_wps_last", wps_n, 1);
    tick();
    check("dc_wps_done", wps_n, 0);
    step_fwd();
    check("dc_dirty_clr", save_req, 0);

    // Random traffic against the model, with occasional mid-run resets.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (i % 997 == 996) do_reset();
      if ($urandom_range(0, 1) == 1) stp = stp + 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) mtr = ~mtr;
      if ($urandom_range(0, 15) == 0) side = ~side;
      buff_we       = ($urandom_range(0, 3) == 0);
      save_ack      = ($urandom_range(0, 4) == 0);
      disk_readonly = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 299) == 0) disk_change = ~disk_change;
      tick();
    end
    save_ack = 0;
    buff_we  = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/drive_head_ctrl.md
# drive_head_ctrl

Parametrised head-position and dirty-track controller for the emulated floppy drive; it sits between the drive logic (stepper phases, motor, side select) and the track buffer/SD loader. It decodes stepper-phase transitions into a bounded half-track position and generates the write-protect sense, including the disk-change pulse. It tracks per-track modification and issues save requests through a small queued handshake, so no save is lost while the loader is busy. It generalises the single-sided 35/40-track head logic to configurable track range and two sides.

## Interface
- HT_MAX, 80: highest legal half-track, ≤127.
- HT_RESET, 36: half-track loaded on reset (track 18).
- SIDES, 1: 1 or 2. When 1, `side` is ignored and treated as 0.
- CHG_TICKS, 15000000: length of the write-protect toggle after a disk change, in clk cycles.
- QDEPTH, 2: save-queue depth, ≥1.

Ports (one clock; reset is synchronous and active-high):
- clk in 1: drive clock (clk_c1541 domain).
- reset in 1: synchronous, active-high.
- stp in 2: stepper phase from the drive logic.
- mtr in 1: spindle motor on.
- side in 1: head select.
- buff_we in 1: track-buffer write strobe.
- disk_change in 1: level; rising edge marks a new image.
- disk_readonly in 1: image read-only flag, sampled on the disk_change rising edge.
- track out 7: half_track[6:1].
- half_track out 7: current half-track.
- side_o out 1: registered active side.
- tr00_sense_n out 1: 0 when track==0.
- wps_n out 1: write-protect sense, active-low.
- save_req out 1: queue non-empty.
- save_trk out 7: track of the head entry.
- save_side out 1: side of the head entry.
- save_ack in 1: one-cycle pop of the head entry.
- save_ovf out 1: sticky; a save was dropped because the queue was full.

## Operation
- **Step decode.** Only while mtr=1, using stp_r (stp delayed 1 cycle):
  - Forward (0→1, 1→2, 2→3, 3→0): increment half_track, saturating at HT_MAX.
  - Backward (0→3, 3→2, 2→1, 1→0): decrement half_track, saturating at 1.
  - Change by 2, or no change: ignored.
- **Dirty flag.** Set by buff_we; cleared on reset, on the disk_change rising edge, and whenever a save is enqueued.
- **Save triggers.** Each trigger enqueues {old track, old side} only if dirty or buff_we is high in that cycle. A write in the same cycle as a trigger belongs to the old track. Triggers:
  - a step that is accepted or saturated;
  - a side change (SIDES=2);
  - mtr falling edge.
  Coincident triggers in one cycle produce exactly one entry.
- **Queue.** FIFO; save_req = !empty.
  - Push and pop in the same cycle is legal, even when full.
  - Push while full and no pop: entry dropped, save_ovf=1 until reset.
  - disk_change rising edge flushes the queue (stale image).
  - save_ack while empty: ignored.
- **Write protect.** readonly latched on the disk_change rising edge. Counter loads CHG_TICKS and counts to 0. wps_n = ~readonly ^ (counter≠0).

## Timing
- Reset values: half_track=HT_RESET, track=HT_RESET>>1, side_o=0, tr00_sense_n=1, save_req=0, save_trk=0, save_side=0, save_ovf=0, wps_n=1 (readonly=0, counter=0), dirty=0, stp_r=0.
- stp changes in cycle N → half_track/track updated in N+1 → queued entry shows save_req=1 in N+1.
- save_ack in N → next entry (or save_req=0) in N+1.
- disk_change edge in N → counter≠0 and queue empty from N+1 for CHG_TICKS cycles.
- Reset mid-operation: all state returns to reset values; no save is emitted.

## Structure
- Package drive_pkg holds:
  - typedef save_entry_t {side, trk[6:0]};
  - step-direction enum {STEP_NONE, STEP_FWD, STEP_BACK} and the decode function step_dir(prev, cur);
  - the HT width constant 7.
- Sub-module drive_save_fifo (QDEPTH entries of save_entry_t, push/pop/flush/full/empty) holds the queue. Everything else lives in the top module.

## Test plan
- Reset with HT_RESET=36 → track=18, wps_n=1, save_req=0. Drive stp 0→1→2→3→0 with mtr=1 → half_track=40, track=20.
- Backward-step 50 times from 36 → half_track stays at 1, tr00_sense_n=0. Forward from HT_MAX=84 → stays at 84. Steps with mtr=0 → no movement.
- buff_we at track 18, then one forward step → save_req=1, save_trk=18, save_side=0. save_ack → save_req=0.
- QDEPTH=2: dirty-step three times with no ack → entries 18, 18, then save_ovf=1. Ack twice → save_req=0, ovf stays 1.
- SIDES=2: write, toggle side → entry {side 0, trk 18}. Write, drop mtr → entry {side 1, trk 18}. Step, side toggle and mtr fall in one cycle → exactly one entry.
- disk_readonly=1, disk_change pulse, CHG_TICKS=100 → wps_n=1 for 100 cycles then 0; pending queue flushed, dirty cleared.
